// File: rtl/qs_bank_ctrl.sv
// qs_bank_ctrl: controller for a ring of sort banks. Each bank is loaded,
// handed to an external sorter, and then unloaded. Three round-robin pointers
// (write, sort, read) move through the ring, so the three phases can work on
// different banks at the same time while results still leave in load order.
//
// Optional feature macro: QS_BANK_CTRL_OVERFLOW_ERR_EN
//   Defined  : a vector longer than N words is cut off at N words. The bank is
//              flagged with err, and the rest of that vector is accepted and dropped.
//   Undefined: the write address wraps and overwrites earlier words. err is
//              set only by the sorter.

module qs_bank_ctrl #(
   parameter int BANKS_N = 4,
   parameter int N       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_vld,
   input  logic                       wr_last,
   output logic                       wr_rdy,
   output logic [$clog2(BANKS_N)-1:0] wr_bank,
   output logic [$clog2(N)-1:0]       wr_addr,
   output logic                       sort_start,
   output logic [$clog2(BANKS_N)-1:0] sort_bank,
   input  logic                       sort_done,
   input  logic                       sort_err,
   output logic                       rd_vld,
   input  logic                       rd_rdy,
   output logic [$clog2(BANKS_N)-1:0] rd_bank,
   output logic [$clog2(N)-1:0]       rd_addr,
   output logic                       rd_last,
   output logic                       rd_err,
   output logic                       busy
);

   localparam int BW = $clog2(BANKS_N);
   localparam int AW = $clog2(N);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOADING,
      ST_READY,
      ST_SORTING,
      ST_SORTED,
      ST_UNLOADING
   } bank_state_e;

   bank_state_e       status_q [BANKS_N];
   bank_state_e       status_d [BANKS_N];
   logic [AW-1:0]     n_q      [BANKS_N];
   logic [AW-1:0]     n_d      [BANKS_N];
   logic [BANKS_N-1:0] err_q, err_d;

   logic [BW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [BW-1:0]     sort_ptr_q, sort_ptr_d;
   logic [BW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              rd_vld_q, rd_vld_d;
   logic              sort_start_q, sort_start_d;

   logic              any_sorting;
   logic              wr_accept;

`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
   localparam logic [AW-1:0] ADDR_MAX = AW'(N - 1);
   logic              discard_q, discard_d;
`endif

   assign wr_bank    = wr_ptr_q;
   assign wr_addr    = wr_addr_q;
   assign sort_bank  = sort_ptr_q;
   assign sort_start = sort_start_q;
   assign rd_bank    = rd_ptr_q;
   assign rd_addr    = rd_addr_q;
   assign rd_vld     = rd_vld_q;

   // Status summaries and handshake outputs, all derived from registered state only
   always_comb begin
      any_sorting = 1'b0;
      busy        = 1'b0;
      for (int i = 0; i < BANKS_N; i++) begin
         if (status_q[i] == ST_SORTING) any_sorting = 1'b1;
         if (status_q[i] != ST_IDLE)    busy        = 1'b1;
      end
      wr_rdy = (status_q[wr_ptr_q] == ST_IDLE) || (status_q[wr_ptr_q] == ST_LOADING);
`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
      // While the tail of an overlong vector is being dropped, no bank is involved
      if (discard_q) wr_rdy = 1'b1;
`endif
      rd_last = rd_vld_q && (rd_addr_q == n_q[rd_ptr_q]);
      rd_err  = rd_vld_q && err_q[rd_ptr_q];
   end

   // Next-state logic: the load, sort and unload stages only touch banks in their
   // own states, so their updates never collide on the same bank in one cycle
   always_comb begin
      status_d     = status_q;
      n_d          = n_q;
      err_d        = err_q;
      wr_ptr_d     = wr_ptr_q;
      sort_ptr_d   = sort_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      rd_vld_d     = rd_vld_q;
      sort_start_d = 1'b0;
`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
      discard_d    = discard_q;
`endif
      wr_accept    = wr_vld && wr_rdy;

      if (wr_accept) begin
`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
         if (discard_q) begin
            if (wr_last) discard_d = 1'b0;
         end else
`endif
         begin
            status_d[wr_ptr_q] = ST_LOADING;
            if (wr_last) begin
               n_d[wr_ptr_q]      = wr_addr_q;
               status_d[wr_ptr_q] = ST_READY;
               wr_addr_d          = '0;
               wr_ptr_d           = wr_ptr_q + 1'b1;
            end
`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
            else if (wr_addr_q == ADDR_MAX) begin
               n_d[wr_ptr_q]      = ADDR_MAX;
               err_d[wr_ptr_q]    = 1'b1;
               status_d[wr_ptr_q] = ST_READY;
               wr_addr_d          = '0;
               wr_ptr_d           = wr_ptr_q + 1'b1;
               discard_d          = 1'b1;
            end
`endif
            else begin
               wr_addr_d = wr_addr_q + 1'b1;
            end
         end
      end

      if (status_q[sort_ptr_q] == ST_READY && !any_sorting) begin
         status_d[sort_ptr_q] = ST_SORTING;
         sort_start_d         = 1'b1;
      end

      if (sort_done && any_sorting) begin
         status_d[sort_ptr_q] = ST_SORTED;
         err_d[sort_ptr_q]    = err_q[sort_ptr_q] | sort_err;
         sort_ptr_d           = sort_ptr_q + 1'b1;
      end

      if (!rd_vld_q && status_q[rd_ptr_q] == ST_SORTED) begin
         status_d[rd_ptr_q] = ST_UNLOADING;
         rd_vld_d           = 1'b1;
         rd_addr_d          = '0;
      end

      if (rd_vld_q && rd_rdy) begin
         if (rd_last) begin
            status_d[rd_ptr_q] = ST_IDLE;
            err_d[rd_ptr_q]    = 1'b0;
            rd_vld_d           = 1'b0;
            rd_addr_d          = '0;
            rd_ptr_d           = rd_ptr_q + 1'b1;
         end else begin
            rd_addr_d = rd_addr_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset that abandons every bank
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BANKS_N; i++) begin
            status_q[i] <= ST_IDLE;
            n_q[i]      <= '0;
         end
         err_q        <= '0;
         wr_ptr_q     <= '0;
         sort_ptr_q   <= '0;
         rd_ptr_q     <= '0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         rd_vld_q     <= 1'b0;
         sort_start_q <= 1'b0;
`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
         discard_q    <= 1'b0;
`endif
      end else begin
         status_q     <= status_d;
         n_q          <= n_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         sort_ptr_q   <= sort_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         rd_vld_q     <= rd_vld_d;
         sort_start_q <= sort_start_d;
`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
         discard_q    <= discard_d;
`endif
      end
   end

endmodule

// File: tb/tb_qs_bank_ctrl.sv
// tb_qs_bank_ctrl: directed bench for qs_bank_ctrl with BANKS_N=4, N=16.
// Expected values for the overlong-vector case follow QS_BANK_CTRL_OVERFLOW_ERR_EN.

module tb_qs_bank_ctrl;

   logic       clk;
   logic       rst;
   logic       wr_vld;
   logic       wr_last;
   logic       wr_rdy;
   logic [1:0] wr_bank;
   logic [3:0] wr_addr;
   logic       sort_start;
   logic [1:0] sort_bank;
   logic       sort_done;
   logic       sort_err;
   logic       rd_vld;
   logic       rd_rdy;
   logic [1:0] rd_bank;
   logic [3:0] rd_addr;
   logic       rd_last;
   logic       rd_err;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int starts_cnt = 0;
   int starts_consumed = 0;

`ifdef QS_BANK_CTRL_OVERFLOW_ERR_EN
   localparam int OVF_LEN = 16;
   localparam int OVF_ERR = 1;
`else
   localparam int OVF_LEN = 4;
   localparam int OVF_ERR = 0;
`endif

   qs_bank_ctrl #(.BANKS_N(4), .N(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_vld     (wr_vld),
      .wr_last    (wr_last),
      .wr_rdy     (wr_rdy),
      .wr_bank    (wr_bank),
      .wr_addr    (wr_addr),
      .sort_start (sort_start),
      .sort_bank  (sort_bank),
      .sort_done  (sort_done),
      .sort_err   (sort_err),
      .rd_vld     (rd_vld),
      .rd_rdy     (rd_rdy),
      .rd_bank    (rd_bank),
      .rd_addr    (rd_addr),
      .rd_last    (rd_last),
      .rd_err     (rd_err),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count sort_start pulses so a launch that happens during a load is not missed
   always @(negedge clk) begin
      if (sort_start === 1'b1) starts_cnt <= starts_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic vld, input logic last, input logic sdone,
                                input logic serr, input logic rdy);
      wr_vld    = vld;
      wr_last   = last;
      sort_done = sdone;
      sort_err  = serr;
      rd_rdy    = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      $display("[TB] reset values check: %s", tag);
      checkOutput("rst_wr_rdy", wr_rdy, 1);
      checkOutput("rst_sort_start", sort_start, 0);
      checkOutput("rst_rd_vld", rd_vld, 0);
      checkOutput("rst_rd_last", rd_last, 0);
      checkOutput("rst_rd_err", rd_err, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_wr_bank", wr_bank, 0);
      checkOutput("rst_sort_bank", sort_bank, 0);
      checkOutput("rst_rd_bank", rd_bank, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_rd_addr", rd_addr, 0);
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      starts_consumed = starts_cnt;
   endtask

   // Push one vector of len words, waiting (bounded) for wr_rdy before each word
   task automatic loadVector(input int len);
      for (int i = 0; i < len; i++) begin
         int cnt = 0;
         wr_vld  = 1'b0;
         wr_last = 1'b0;
         while (!wr_rdy && cnt < 60) begin
            tick();
            cnt++;
         end
         checkOutput("load_wr_rdy_wait", wr_rdy, 1);
         wr_vld  = 1'b1;
         wr_last = (i == len - 1);
         tick();
      end
      wr_vld  = 1'b0;
      wr_last = 1'b0;
   endtask

   // Wait for an unanswered sort launch, then answer it two cycles later
   task automatic sortRespond(input int bank, input logic err);
      int cnt = 0;
      while (starts_cnt == starts_consumed && cnt < 60) begin
         tick();
         cnt++;
      end
      checkOutput("sort_start_seen", (starts_cnt > starts_consumed), 1);
      starts_consumed++;
      checkOutput("sort_bank_held", sort_bank, bank);
      tick();
      tick();
      sort_done = 1'b1;
      sort_err  = err;
      tick();
      sort_done = 1'b0;
      sort_err  = 1'b0;
   endtask

   // Drain one bank and check every presented word; toggle=1 stalls every other cycle
   task automatic unloadVector(input int bank, input int len, input int err, input bit toggle);
      int cnt = 0;
      int k = 0;
      bit phase = 1'b0;
      while (!rd_vld && cnt < 60) begin
         tick();
         cnt++;
      end
      checkOutput("unload_rd_vld_wait", rd_vld, 1);
      cnt = 0;
      while (k < len && cnt < 200) begin
         rd_rdy = toggle ? phase : 1'b1;
         checkOutput("unload_rd_vld", rd_vld, 1);
         checkOutput("unload_rd_bank", rd_bank, bank);
         checkOutput("unload_rd_addr", rd_addr, k);
         checkOutput("unload_rd_last", rd_last, (k == len - 1));
         checkOutput("unload_rd_err", rd_err, err);
         if (rd_rdy) k++;
         phase = ~phase;
         cnt++;
         tick();
      end
      rd_rdy = 1'b0;
      checkOutput("unload_count", k, len);
      checkOutput("unload_rd_vld_drop", rd_vld, 0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      checkResetValues("power-up");

      // Five-word vector into bank 0, sorter answers three cycles after launch
      $display("[TB] single five-word vector");
      for (int i = 0; i < 5; i++) begin
         checkOutput("t1_wr_addr", wr_addr, i);
         checkOutput("t1_wr_rdy", wr_rdy, 1);
         applyStimulus(1, (i == 4), 0, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t1_wr_bank_adv", wr_bank, 1);
      checkOutput("t1_wr_addr_clr", wr_addr, 0);
      checkOutput("t1_no_start_yet", sort_start, 0);
      checkOutput("t1_busy", busy, 1);
      tick();
      checkOutput("t1_sort_start", sort_start, 1);
      checkOutput("t1_sort_bank", sort_bank, 0);
      tick();
      checkOutput("t1_sort_start_pulse", sort_start, 0);
      tick();
      tick();
      applyStimulus(0, 0, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t1_sort_ptr_adv", sort_bank, 1);
      checkOutput("t1_rd_vld_pre", rd_vld, 0);
      tick();
      starts_consumed = starts_cnt;
      unloadVector(0, 5, 0, 1'b0);
      checkOutput("t1_busy_done", busy, 0);
      checkOutput("t1_rd_bank_adv", rd_bank, 1);

      // Sorter error on bank 1 only; bank 2 holds a single-word vector
      $display("[TB] sorter error propagation");
      doReset();
      loadVector(2);
      sortRespond(0, 1'b0);
      loadVector(3);
      sortRespond(1, 1'b1);
      loadVector(1);
      sortRespond(2, 1'b0);
      unloadVector(0, 2, 0, 1'b0);
      unloadVector(1, 3, 1, 1'b0);
      unloadVector(2, 1, 0, 1'b0);
      checkOutput("t2_busy_done", busy, 0);

      // Eight-word vector drained with rd_rdy alternating 0/1
      $display("[TB] stalled unload");
      doReset();
      loadVector(8);
      sortRespond(0, 1'b0);
      unloadVector(0, 8, 0, 1'b1);
      checkOutput("t3_busy_done", busy, 0);

      // All four banks occupied: fifth vector waits for bank 0 to drain
      $display("[TB] full ring back-pressure");
      doReset();
      loadVector(2);
      sortRespond(0, 1'b0);
      loadVector(2);
      loadVector(2);
      loadVector(2);
      checkOutput("t4_full_wr_rdy", wr_rdy, 0);
      checkOutput("t4_full_wr_bank", wr_bank, 0);
      checkOutput("t4_bank0_unloading", rd_vld, 1);
      applyStimulus(1, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      checkOutput("t4_stall_wr_rdy", wr_rdy, 0);
      checkOutput("t4_stall_wr_addr", wr_addr, 0);
      rd_rdy = 1'b1;
      checkOutput("t4_rd_addr0", rd_addr, 0);
      tick();
      checkOutput("t4_rd_last", rd_last, 1);
      checkOutput("t4_wr_rdy_before", wr_rdy, 0);
      tick();
      rd_rdy = 1'b0;
      checkOutput("t4_wr_rdy_rise", wr_rdy, 1);
      checkOutput("t4_wr_bank_0", wr_bank, 0);
      checkOutput("t4_wr_addr_0", wr_addr, 0);
      wr_last = 1'b1;
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t4_fifth_wr_bank", wr_bank, 1);
      checkOutput("t4_fifth_wr_rdy", wr_rdy, 0);

      // Reset while bank 0 sorts and bank 1 loads; a late sort_done is ignored
      $display("[TB] reset mid-operation");
      doReset();
      loadVector(3);
      begin
         int cnt = 0;
         while (starts_cnt == starts_consumed && cnt < 60) begin
            tick();
            cnt++;
         end
         checkOutput("t5_sort_launched", (starts_cnt > starts_consumed), 1);
         starts_consumed = starts_cnt;
      end
      applyStimulus(1, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t5_pre_wr_bank", wr_bank, 1);
      checkOutput("t5_pre_wr_addr", wr_addr, 1);
      checkOutput("t5_pre_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkResetValues("mid-operation");
      applyStimulus(0, 0, 1, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("t5_late_done_busy", busy, 0);
      checkOutput("t5_late_done_sort_bank", sort_bank, 0);
      checkOutput("t5_late_done_rd_vld", rd_vld, 0);
      checkOutput("t5_late_done_rd_err", rd_err, 0);

      // Twenty-word vector into a sixteen-word bank
      $display("[TB] overlong vector");
      doReset();
      loadVector(20);
      checkOutput("t6_wr_bank", wr_bank, 1);
      checkOutput("t6_wr_addr", wr_addr, 0);
      sortRespond(0, 1'b0);
      unloadVector(0, OVF_LEN, OVF_ERR, 1'b0);
      checkOutput("t6_busy_done", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
